// File: rtl/blaster_pkg.sv
// Shared types and limits for the host UART bridge.
package blaster_pkg;

  localparam int unsigned BLASTER_MIN_CLKS_PER_BIT = 4;

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_t;

  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxWaitIdle} rx_state_t;

endpackage

// File: rtl/blaster_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; push while full succeeds only with a pop.
module blaster_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] LevelFull = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_full    = (r_level == LevelFull);
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  // Head reads as zero while empty so stale storage never leaks out.
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop) begin
        r_level <= r_level + 1'b1;
      end else if (!w_do_push && w_do_pop) begin
        r_level <= r_level - 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/blaster_uart_bridge.sv
// UART line to valid/ready byte streams: oversampling RX deframer, TX framer, two FIFOs,
// sticky error flags and an internal TX-to-RX loopback for bring-up.
module blaster_uart_bridge
  import blaster_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 25,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_rx,
  output logic                          o_tx,
  input  logic                          i_loopback,
  input  logic [DATA_BITS-1:0]          s_tx_data,
  input  logic                          s_tx_valid,
  output logic                          s_tx_ready,
  output logic [DATA_BITS-1:0]          m_rx_data,
  output logic                          m_rx_valid,
  input  logic                          m_rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_rx_level,
  output logic [$clog2(FIFO_DEPTH):0]   o_tx_level,
  output logic                          o_frame_err,
  output logic                          o_rx_overrun,
  input  logic                          i_clear_err,
  output logic                          o_busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] BitLast  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HalfLast = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] IdxLast  = BW'(DATA_BITS - 1);

  if (CLKS_PER_BIT < BLASTER_MIN_CLKS_PER_BIT) begin : g_bad_cpb
    $error("CLKS_PER_BIT must be at least 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("DATA_BITS must be in 5..9");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end

  tx_state_t r_tx_state, w_tx_state_next;
  rx_state_t r_rx_state, w_rx_state_next;

  logic [CW-1:0]          r_tx_cnt, r_rx_cnt;
  logic [BW-1:0]          r_tx_idx, r_rx_idx;
  logic [DATA_BITS-1:0]   r_tx_shift, r_rx_shift;
  logic [DATA_BITS-1:0]   w_tx_fifo_data;
  logic [SYNC_STAGES-1:0] r_sync;
  logic r_tx_line, r_rx_prev, r_rx_done, r_loopback, r_frame_err, r_rx_overrun;
  logic w_tx_pop, w_tx_bit, w_tx_bit_end, w_tx_full, w_tx_empty;
  logic w_rx_line, w_rx_bit_end, w_rx_half, w_rx_sample, w_rx_stop_ok, w_rx_stop_bad;
  logic w_rx_pop, w_rx_full, w_rx_empty;

  // ---------------- TX framer ----------------
  assign w_tx_bit_end = (r_tx_cnt == BitLast);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_tx_state <= TxIdle;
    else            r_tx_state <= w_tx_state_next;
  end

  always_comb begin
    w_tx_state_next = r_tx_state;
    unique case (r_tx_state)
      TxIdle:  if (!w_tx_empty) w_tx_state_next = TxStart;
      TxStart: if (w_tx_bit_end) w_tx_state_next = TxData;
      TxData:  if (w_tx_bit_end && r_tx_idx == IdxLast) w_tx_state_next = TxStop;
      TxStop:  if (w_tx_bit_end) w_tx_state_next = w_tx_empty ? TxIdle : TxStart;
      default: w_tx_state_next = TxIdle;
    endcase
  end

  always_comb begin
    w_tx_pop = 1'b0;
    w_tx_bit = 1'b1;
    unique case (r_tx_state)
      TxIdle:  w_tx_pop = ~w_tx_empty;
      TxStart: w_tx_bit = 1'b0;
      TxData:  w_tx_bit = r_tx_shift[0];
      TxStop:  w_tx_pop = w_tx_bit_end & ~w_tx_empty;
      default: w_tx_bit = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_shift <= '0;
      r_tx_line  <= 1'b1;
    end else begin
      r_tx_line <= w_tx_bit;
      if (w_tx_pop) begin
        r_tx_shift <= w_tx_fifo_data;
        r_tx_cnt   <= '0;
        r_tx_idx   <= '0;
      end else if (r_tx_state != TxIdle) begin
        if (w_tx_bit_end) begin
          r_tx_cnt <= '0;
          if (r_tx_state == TxData) begin
            r_tx_shift <= r_tx_shift >> 1;
            r_tx_idx   <= r_tx_idx + 1'b1;
          end
        end else begin
          r_tx_cnt <= r_tx_cnt + 1'b1;
        end
      end
    end
  end

  // ---------------- RX deframer ----------------
  // Loopback feeds the TX bit straight in; it is already synchronous.
  assign w_rx_line    = r_loopback ? r_tx_line : r_sync[SYNC_STAGES-1];
  assign w_rx_bit_end = (r_rx_cnt == BitLast);
  assign w_rx_half    = (r_rx_cnt == HalfLast);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_rx_state <= RxIdle;
    else            r_rx_state <= w_rx_state_next;
  end

  always_comb begin
    w_rx_state_next = r_rx_state;
    unique case (r_rx_state)
      RxIdle:     if (r_rx_prev && !w_rx_line) w_rx_state_next = RxStart;
      RxStart:    if (w_rx_half) w_rx_state_next = w_rx_line ? RxIdle : RxData;
      RxData:     if (w_rx_bit_end && r_rx_idx == IdxLast) w_rx_state_next = RxStop;
      RxStop:     if (w_rx_bit_end) w_rx_state_next = w_rx_line ? RxIdle : RxWaitIdle;
      RxWaitIdle: if (w_rx_line) w_rx_state_next = RxIdle;
      default:    w_rx_state_next = RxIdle;
    endcase
  end

  always_comb begin
    w_rx_sample   = 1'b0;
    w_rx_stop_ok  = 1'b0;
    w_rx_stop_bad = 1'b0;
    unique case (r_rx_state)
      RxData: w_rx_sample = w_rx_bit_end;
      RxStop: begin
        w_rx_stop_ok  = w_rx_bit_end & w_rx_line;
        w_rx_stop_bad = w_rx_bit_end & ~w_rx_line;
      end
      default: w_rx_sample = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync     <= '1;
      r_rx_prev  <= 1'b1;
      r_rx_done  <= 1'b0;
      r_rx_cnt   <= '0;
      r_rx_idx   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], i_rx};
      r_rx_prev <= w_rx_line;
      r_rx_done <= w_rx_stop_ok;
      if (w_rx_state_next != r_rx_state || r_rx_state == RxIdle || w_rx_bit_end) begin
        r_rx_cnt <= '0;
      end else begin
        r_rx_cnt <= r_rx_cnt + 1'b1;
      end
      if (r_rx_state == RxStart) begin
        r_rx_idx <= '0;
      end else if (w_rx_sample) begin
        r_rx_idx   <= r_rx_idx + 1'b1;
        r_rx_shift <= {w_rx_line, r_rx_shift[DATA_BITS-1:1]};
      end
    end
  end

  // ---------------- Flags, loopback, status ----------------
  assign w_rx_pop = m_rx_ready & ~w_rx_empty;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_frame_err  <= 1'b0;
      r_rx_overrun <= 1'b0;
      r_loopback   <= 1'b0;
    end else begin
      if (w_rx_stop_bad)    r_frame_err <= 1'b1;
      else if (i_clear_err) r_frame_err <= 1'b0;
      if (r_rx_done && w_rx_full && !w_rx_pop) r_rx_overrun <= 1'b1;
      else if (i_clear_err)                    r_rx_overrun <= 1'b0;
      if (r_tx_state == TxIdle && r_rx_state == RxIdle) r_loopback <= i_loopback;
    end
  end

  assign o_tx         = r_loopback | r_tx_line;
  assign s_tx_ready   = ~w_tx_full;
  assign m_rx_valid   = ~w_rx_empty;
  assign o_frame_err  = r_frame_err;
  assign o_rx_overrun = r_rx_overrun;
  assign o_busy       = (r_tx_state != TxIdle) | ~w_tx_empty | (r_rx_state != RxIdle);

  blaster_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_push    (s_tx_valid & ~w_tx_full),
    .i_data    (s_tx_data),
    .i_pop     (w_tx_pop),
    .o_data    (w_tx_fifo_data),
    .o_full    (w_tx_full),
    .o_empty   (w_tx_empty),
    .o_level   (o_tx_level)
  );

  blaster_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_push    (r_rx_done),
    .i_data    (r_rx_shift),
    .i_pop     (w_rx_pop),
    .o_data    (m_rx_data),
    .o_full    (w_rx_full),
    .o_empty   (w_rx_empty),
    .o_level   (o_rx_level)
  );

endmodule
